datapath_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one arithmetic datapath (A/B/opcode in, Y/co out, fixed latency) between two requesters. It grants at most one operation per cycle and tracks each operation through the datapath latency with a tag pipeline. Results are returned in issue order through a credit-protected result FIFO, so the non-stallable datapath never loses a result under response backpressure. It sits between the requester blocks and the `datapath` instance and drives that instance's A, B and opcode inputs directly.

---
 rtl/datapath_arbiter.sv | 167 ++++++++++++++++
 tb/tb_datapath_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter sharing one fixed-latency datapath between two
// requesters, with a tag pipeline and a credit-protected in-order result FIFO.
`timescale 1ns/1ps
module datapath_arbiter #(
  parameter int N     = 16,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [2:0]   req_op0,
  input  logic [2:0]   req_op1,
  output logic [N-1:0] dp_a,
  output logic [N-1:0] dp_b,
  output logic [2:0]   dp_op,
  input  logic [N-1:0] dp_y,
  input  logic         dp_co,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_y,
  output logic         rsp_co,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);
  localparam logic [AW-1:0] PLAST = AW'(DEPTH - 1);

  typedef struct packed {
    logic         id;
    logic [N-1:0] y;
    logic         co;
  } ent_t;

  logic [CW-1:0] cnt;
  logic          prio;
  logic [1:0]    gnt;
  logic          credit;
  logic          issue;
  logic          iss_id;
  logic          wr;
  logic          wid;
  logic          pop;
  logic          empty;
  logic          full;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] occ;
  ent_t          mem [DEPTH];
  ent_t          head;

  // Grant selection: lone requester wins, otherwise the favoured one.
  always_comb begin
    gnt = 2'b00;
    case (1'b1)
      (req_valid == 2'b11): gnt = prio ? 2'b10 : 2'b01;
      default:              gnt = req_valid;
    endcase
  end

  // A pop frees its credit only on the following cycle.
  assign credit    = (cnt < CMAX) & ~rst;
  assign req_ready = gnt & {2{credit}};
  assign issue     = |req_ready;
  assign iss_id    = req_ready[1];

  // Drive the datapath with the granted operands, zeros when idle.
  always_comb begin
    dp_a  = '0;
    dp_b  = '0;
    dp_op = '0;
    if (issue) begin
      dp_a  = iss_id ? req_a1  : req_a0;
      dp_b  = iss_id ? req_b1  : req_b0;
      dp_op = iss_id ? req_op1 : req_op0;
    end
  end

  // Priority flips to the other requester after every issue.
  always_ff @(posedge clk) begin
    if (rst) prio <= 1'b0;
    else if (issue) prio <= ~iss_id;
  end

  // Credits: in-flight operations plus buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign busy = (cnt != '0);

  generate
    if (LAT == 0) begin : g_comb
      assign wr  = issue;
      assign wid = iss_id;
    end else begin : g_tag
      logic [LAT-1:0] tv;
      logic [LAT-1:0] tid;
      // Tag shift register tracking each op through the datapath.
      always_ff @(posedge clk) begin
        if (rst) begin
          tv  <= '0;
          tid <= '0;
        end else begin
          tv[0]  <= issue;
          tid[0] <= iss_id;
          for (int s = 1; s < LAT; s++) begin
            tv[s]  <= tv[s-1];
            tid[s] <= tid[s-1];
          end
        end
      end
      assign wr  = tv[LAT-1];
      assign wid = tid[LAT-1];
    end
  endgenerate

  assign empty = (occ == '0);
  assign full  = (occ == CMAX);
  assign pop   = ~empty & rsp_ready;

  // FIFO pointers and occupancy; credits make overflow unreachable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      assert (!(wr && full));
      if (wr)  wp <= (wp == PLAST) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == PLAST) ? '0 : rp + 1'b1;
      case ({wr, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Result storage; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[wp] <= '{id: wid, y: dp_y, co: dp_co};
  end

  assign head      = mem[rp];
  assign rsp_valid = ~empty;
  assign rsp_id    = empty ? 1'b0 : head.id;
  assign rsp_y     = empty ? '0   : head.y;
  assign rsp_co    = empty ? 1'b0 : head.co;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter with a registered (LAT=1)
// datapath model in the loop.
`timescale 1ns/1ps
module tb_datapath_arbiter;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]   req_op0, req_op1;
  logic [N-1:0] dp_a, dp_b;
  logic [2:0]   dp_op;
  logic [N-1:0] dp_y;
  logic         dp_co;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_co, busy;
  logic [N-1:0] rsp_y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  datapath_arbiter #(.N(N), .LAT(1), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .dp_y(dp_y), .dp_co(dp_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_co(rsp_co),
    .busy(busy)
  );

  function automatic logic [N:0] dp_f(
    input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    logic [N-1:0] bb;
    bb = op[2] ? '0 : b;
    bb = bb ^ (op[1] ? {N{1'b1}} : {N{1'b0}});
    return {1'b0, a} + {1'b0, bb} + (N+1)'(op[0]);
  endfunction

  always @(posedge clk) {dp_co, dp_y} <= dp_f(dp_a, dp_b, dp_op);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
  endtask

  task automatic do_reset();
    idle();
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic         id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic [N-1:0] y;
    logic         co;
  } vec_t;

  vec_t v[10];

  int bnext;
  int acc;
  logic [N-1:0] ys[$];
  logic         ids[$];

  task automatic bp_cycle();
    req_valid = (bnext <= 6) ? 2'b10 : 2'b00;
    req_a1 = '0;
    req_b1 = N'(bnext);
    req_op1 = 3'b000;
    #1;
    if (req_ready[1]) begin
      acc++;
      bnext++;
    end
    if (rsp_valid && rsp_ready) begin
      ys.push_back(rsp_y);
      ids.push_back(rsp_id);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    v[0] = '{1'b0, 16'h0005, 16'h0003, 3'b000, 16'h0008, 1'b0};
    v[1] = '{1'b1, 16'h0003, 16'h0005, 3'b011, 16'hFFFE, 1'b0};
    v[2] = '{1'b0, 16'h8000, 16'h8000, 3'b000, 16'h0000, 1'b1};
    v[3] = '{1'b1, 16'h1234, 16'h5555, 3'b100, 16'h1234, 1'b0};
    v[4] = '{1'b0, 16'h0007, 16'h0007, 3'b011, 16'h0000, 1'b1};
    v[5] = '{1'b1, 16'hFFFF, 16'h0001, 3'b001, 16'h0001, 1'b1};
    v[6] = '{1'b0, 16'h0010, 16'h1111, 3'b110, 16'h000F, 1'b1};
    v[7] = '{1'b1, 16'hFFFF, 16'h2222, 3'b101, 16'h0000, 1'b1};
    v[8] = '{1'b0, 16'h0100, 16'h0001, 3'b010, 16'h00FE, 1'b1};
    v[9] = '{1'b1, 16'hABCD, 16'h0F0F, 3'b111, 16'hABCD, 1'b1};

    idle();
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    req_valid = 2'b11;
    #1;
    chk("ready_in_reset", 32'(req_ready), 32'h0);
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_y", 32'(rsp_y), 0);
    chk("rst_rsp_co", 32'(rsp_co), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dp_a", 32'(dp_a), 0);
    chk("rst_dp_op", 32'(dp_op), 0);

    for (int i = 0; i < 10; i++) begin
      if (v[i].id) begin
        req_a1 = v[i].a; req_b1 = v[i].b; req_op1 = v[i].op;
        req_valid = 2'b10;
      end else begin
        req_a0 = v[i].a; req_b0 = v[i].b; req_op0 = v[i].op;
        req_valid = 2'b01;
      end
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready),
          v[i].id ? 32'h2 : 32'h1);
      chk($sformatf("v%0d_dp_a", i), 32'(dp_a), 32'(v[i].a));
      chk($sformatf("v%0d_dp_op", i), 32'(dp_op), 32'(v[i].op));
      tick();
      idle();
      #1;
      chk($sformatf("v%0d_early_valid", i), 32'(rsp_valid), 0);
      chk($sformatf("v%0d_busy", i), 32'(busy), 1);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("v%0d_y", i), 32'(rsp_y), 32'(v[i].y));
      chk($sformatf("v%0d_co", i), 32'(rsp_co), 32'(v[i].co));
      chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(v[i].id));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_popped", i), 32'(rsp_valid), 0);
      chk($sformatf("v%0d_idle", i), 32'(busy), 0);
    end

    do_reset();
    req_a0 = 16'h0100; req_a1 = 16'h0200;
    rsp_ready = 1'b1;
    ys.delete();
    ids.delete();
    for (int c = 0; c < 16; c++) begin
      req_valid = (c < 8) ? 2'b11 : 2'b00;
      #1;
      if (c < 8)
        chk($sformatf("fair_grant%0d", c), 32'(req_ready),
            (c % 2 == 1) ? 32'h2 : 32'h1);
      if (rsp_valid) begin
        ys.push_back(rsp_y);
        ids.push_back(rsp_id);
      end
      tick();
    end
    chk("fair_count", 32'(ys.size()), 8);
    for (int j = 0; j < ys.size(); j++) begin
      chk($sformatf("fair_id%0d", j), 32'(ids[j]), 32'(j % 2));
      chk($sformatf("fair_y%0d", j), 32'(ys[j]),
          (j % 2 == 1) ? 32'h200 : 32'h100);
    end

    do_reset();
    ys.delete();
    ids.delete();
    bnext = 1;
    acc = 0;
    repeat (8) bp_cycle();
    chk("bp_accepted", 32'(acc), 4);
    req_valid = 2'b10;
    req_b1 = N'(bnext);
    #1;
    chk("bp_full_ready", 32'(req_ready), 0);
    chk("bp_head_y", 32'(rsp_y), 1);
    chk("bp_head_id", 32'(rsp_id), 1);
    chk("bp_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    #1;
    chk("bnd_no_issue", 32'(req_ready), 0);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bnd_issue_next", 32'(req_ready), 32'h2);
    chk("bnd_next_head", 32'(rsp_y), 2);
    tick();
    acc++;
    bnext++;
    req_b1 = N'(bnext);
    #1;
    chk("bnd_cnt_full", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    repeat (14) bp_cycle();
    chk("bp_total", 32'(acc), 6);
    chk("bp_drain_count", 32'(ys.size()), 5);
    for (int j = 0; j < ys.size(); j++) begin
      chk($sformatf("bp_y%0d", j), 32'(ys[j]), 32'(j + 2));
      chk($sformatf("bp_id%0d", j), 32'(ids[j]), 1);
    end

    do_reset();
    req_a1 = 16'h0011;
    req_valid = 2'b10;
    #1;
    chk("mid_issue1", 32'(req_ready), 32'h2);
    tick();
    req_a0 = 16'h0022;
    req_valid = 2'b01;
    #1;
    chk("mid_issue2", 32'(req_ready), 32'h1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("mid_quiet%0d", c), 32'(rsp_valid), 0);
    end
    req_valid = 2'b11;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'h1);
    tick();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
